tile_obi2axi_data_bridge: RTL and testbench

//  Converts the tile core's OBI data port into single-beat AXI4 transactions for the tile's data-side AXI slave (L2 sim memory in the VIP).

---
 rtl/tile_obi2axi_data_bridge_if.sv | 73 +++++++
 rtl/tile_obi2axi_data_bridge.sv | 191 +++++++++++++++++++
 tb/tb_tile_obi2axi_data_bridge.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_obi2axi_data_bridge_if.sv
// OBI data port plus single-beat AXI4 data channels seen by the tile OBI-to-AXI bridge.
// The slave modport is the bridge's view; the master modport is the core/memory side.
interface tile_obi2axi_data_bridge_if #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned AXI_DATA_W = 64
);
   logic                    obi_req_i;
   logic                    obi_gnt_o;
   logic [ADDR_W-1:0]       obi_addr_i;
   logic                    obi_we_i;
   logic [DATA_W/8-1:0]     obi_be_i;
   logic [DATA_W-1:0]       obi_wdata_i;
   logic                    obi_rvalid_o;
   logic [DATA_W-1:0]       obi_rdata_o;
   logic                    obi_err_o;

   logic                    axi_aw_valid_o;
   logic                    axi_aw_ready_i;
   logic [ADDR_W-1:0]       axi_aw_addr_o;
   logic [2:0]              axi_aw_size_o;

   logic                    axi_w_valid_o;
   logic                    axi_w_ready_i;
   logic [AXI_DATA_W-1:0]   axi_w_data_o;
   logic [AXI_DATA_W/8-1:0] axi_w_strb_o;
   logic                    axi_w_last_o;

   logic                    axi_b_valid_i;
   logic                    axi_b_ready_o;
   logic [1:0]              axi_b_resp_i;

   logic                    axi_ar_valid_o;
   logic                    axi_ar_ready_i;
   logic [ADDR_W-1:0]       axi_ar_addr_o;
   logic [2:0]              axi_ar_size_o;

   logic                    axi_r_valid_i;
   logic                    axi_r_ready_o;
   logic [AXI_DATA_W-1:0]   axi_r_data_i;
   logic [1:0]              axi_r_resp_i;
   logic                    axi_r_last_i;

   modport slave (
      input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
      output obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
      output axi_aw_valid_o, axi_aw_addr_o, axi_aw_size_o,
      input  axi_aw_ready_i,
      output axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o,
      input  axi_w_ready_i,
      input  axi_b_valid_i, axi_b_resp_i,
      output axi_b_ready_o,
      output axi_ar_valid_o, axi_ar_addr_o, axi_ar_size_o,
      input  axi_ar_ready_i,
      input  axi_r_valid_i, axi_r_data_i, axi_r_resp_i, axi_r_last_i,
      output axi_r_ready_o
   );

   modport master (
      output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
      input  obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
      input  axi_aw_valid_o, axi_aw_addr_o, axi_aw_size_o,
      output axi_aw_ready_i,
      input  axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o,
      output axi_w_ready_i,
      output axi_b_valid_i, axi_b_resp_i,
      input  axi_b_ready_o,
      input  axi_ar_valid_o, axi_ar_addr_o, axi_ar_size_o,
      output axi_ar_ready_i,
      output axi_r_valid_i, axi_r_data_i, axi_r_resp_i, axi_r_last_i,
      input  axi_r_ready_o
   );
endinterface

// File: rtl/tile_obi2axi_data_bridge.sv
// Tile core OBI data port to single-beat AXI4 bridge: one access in flight,
// byte-lane steering, AXI error mapping and a B/R response watchdog.
module tile_obi2axi_data_bridge #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned AXI_DATA_W = 64,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   tile_obi2axi_data_bridge_if.slave       bus,
   output logic                            busy_o
);

   localparam int unsigned BE_W    = DATA_W / 8;
   localparam int unsigned STRB_W  = AXI_DATA_W / 8;
   localparam int unsigned N_LANES = AXI_DATA_W / DATA_W;
   localparam int unsigned LANE_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1;
   localparam int unsigned BOFF_W  = $clog2(BE_W);
   localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [2:0]       AXI_SIZE = 3'(BOFF_W);
   localparam bit               WD_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP, RSP} state_e;

   state_e                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q;
   logic [LANE_W-1:0]     lane_q, lane_in;
   logic [AXI_DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0]     strb_q;
   logic                  aw_valid_q, aw_valid_d;
   logic                  w_valid_q, w_valid_d;
   logic                  ar_valid_q, ar_valid_d;
   logic                  b_ready_q, r_ready_q;
   logic                  rvalid_q, err_q, busy_q;
   logic [DATA_W-1:0]     rdata_q;
   logic [CNT_W-1:0]      wd_cnt_q;

   logic                  capture, wd_clr, rsp_load, rsp_err_d, wd_expired;
   logic [DATA_W-1:0]     rsp_rdata_d, r_slice;
   logic                  unused_bits;

   // Lane of the AXI beat that carries this OBI word
   if (N_LANES > 1) begin : g_lane
      assign lane_in = bus.obi_addr_i[BOFF_W +: LANE_W];
   end else begin : g_no_lane
      assign lane_in = '0;
   end

   assign r_slice     = bus.axi_r_data_i[32'(lane_q) * DATA_W +: DATA_W];
   assign wd_expired  = WD_EN && (wd_cnt_q == WD_LAST);
   assign unused_bits = ^{bus.axi_b_resp_i[0], bus.axi_r_resp_i[0], bus.axi_r_last_i};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      aw_valid_d  = aw_valid_q;
      w_valid_d   = w_valid_q;
      ar_valid_d  = ar_valid_q;
      capture     = 1'b0;
      wd_clr      = 1'b0;
      rsp_load    = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.obi_req_i) begin
               capture = 1'b1;
               if (bus.obi_we_i) begin
                  state_d    = WRITE;
                  aw_valid_d = 1'b1;
                  w_valid_d  = 1'b1;
               end else begin
                  state_d    = READ;
                  ar_valid_d = 1'b1;
               end
            end
         end
         WRITE: begin
            if (aw_valid_q && bus.axi_aw_ready_i) aw_valid_d = 1'b0;
            if (w_valid_q && bus.axi_w_ready_i)   w_valid_d  = 1'b0;
            if (!aw_valid_d && !w_valid_d) begin
               state_d = WRESP;
               wd_clr  = 1'b1;
            end
         end
         WRESP: begin
            if (bus.axi_b_valid_i) begin
               rsp_load  = 1'b1;
               rsp_err_d = bus.axi_b_resp_i[1];
               state_d   = RSP;
            end else if (wd_expired) begin
               rsp_load  = 1'b1;
               rsp_err_d = 1'b1;
               state_d   = RSP;
            end
         end
         READ: begin
            if (bus.axi_ar_ready_i) begin
               ar_valid_d = 1'b0;
               state_d    = RRESP;
               wd_clr     = 1'b1;
            end
         end
         RRESP: begin
            if (bus.axi_r_valid_i) begin
               rsp_load    = 1'b1;
               rsp_err_d   = bus.axi_r_resp_i[1];
               rsp_rdata_d = r_slice;
               state_d     = RSP;
            end else if (wd_expired) begin
               rsp_load  = 1'b1;
               rsp_err_d = 1'b1;
               state_d   = RSP;
            end
         end
         RSP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake and response registers; B/R stay ready in IDLE to absorb late beats
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         ar_valid_q <= 1'b0;
         b_ready_q  <= 1'b0;
         r_ready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         busy_q     <= 1'b0;
      end else begin
         aw_valid_q <= aw_valid_d;
         w_valid_q  <= w_valid_d;
         ar_valid_q <= ar_valid_d;
         b_ready_q  <= (state_d == IDLE) || (state_d == WRESP);
         r_ready_q  <= (state_d == IDLE) || (state_d == RRESP);
         rvalid_q   <= rsp_load;
         err_q      <= rsp_load ? rsp_err_d : 1'b0;
         if (rsp_load) rdata_q <= rsp_rdata_d;
         busy_q     <= (state_d != IDLE);
      end
   end

   // Request payload, steered onto the AXI lane at grant time
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q  <= '0;
         lane_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else if (capture) begin
         addr_q  <= bus.obi_addr_i;
         lane_q  <= lane_in;
         wdata_q <= {N_LANES{bus.obi_wdata_i}};
         strb_q  <= STRB_W'(bus.obi_be_i) << (32'(lane_in) * BE_W);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                    wd_cnt_q <= '0;
      else if (wd_clr)                              wd_cnt_q <= '0;
      else if ((state_q == WRESP) || (state_q == RRESP)) wd_cnt_q <= wd_cnt_q + CNT_W'(1);
   end

   assign bus.obi_gnt_o      = (state_q == IDLE);
   assign bus.obi_rvalid_o   = rvalid_q;
   assign bus.obi_rdata_o    = rdata_q;
   assign bus.obi_err_o      = err_q;
   assign bus.axi_aw_valid_o = aw_valid_q;
   assign bus.axi_aw_addr_o  = addr_q;
   assign bus.axi_aw_size_o  = AXI_SIZE;
   assign bus.axi_w_valid_o  = w_valid_q;
   assign bus.axi_w_data_o   = wdata_q;
   assign bus.axi_w_strb_o   = strb_q;
   assign bus.axi_w_last_o   = 1'b1;
   assign bus.axi_b_ready_o  = b_ready_q;
   assign bus.axi_ar_valid_o = ar_valid_q;
   assign bus.axi_ar_addr_o  = addr_q;
   assign bus.axi_ar_size_o  = AXI_SIZE;
   assign bus.axi_r_ready_o  = r_ready_q;
   assign busy_o             = busy_q;

endmodule

// File: tb/tb_tile_obi2axi_data_bridge.sv
// Directed bench for the OBI-to-AXI data bridge with a 16-cycle response watchdog.
module tb_tile_obi2axi_data_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        busy;
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   tile_obi2axi_data_bridge_if #(.ADDR_W(32), .DATA_W(32), .AXI_DATA_W(64)) bus ();

   tile_obi2axi_data_bridge #(
      .ADDR_W(32), .DATA_W(32), .AXI_DATA_W(64), .TIMEOUT(16)
   ) u_dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus    (bus),
      .busy_o (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wdata, output int unsigned gnt_cyc);
      bus.obi_req_i   = 1'b1;
      bus.obi_addr_i  = addr;
      bus.obi_we_i    = we;
      bus.obi_be_i    = be;
      bus.obi_wdata_i = wdata;
      check("gnt_idle", bus.obi_gnt_o, 1);
      gnt_cyc = cyc;
      tick();
      bus.obi_req_i = 1'b0;
   endtask

   // AW/W slave with independent ready delays; payload checked every valid cycle
   task automatic write_phase(input int aw_dly, input int w_dly, input logic [31:0] exp_addr,
                              input logic [7:0] exp_strb, input logic [63:0] exp_data,
                              output int aw_cyc, output int w_cyc);
      bit aw_done = 0, w_done = 0;
      aw_cyc = 0;
      w_cyc  = 0;
      check("b_ready_in_write", bus.axi_b_ready_o, 0);
      for (int k = 0; k < 40 && !(aw_done && w_done); k++) begin
         bus.axi_aw_ready_i = (k >= aw_dly);
         bus.axi_w_ready_i  = (k >= w_dly);
         if (bus.axi_aw_valid_o) begin
            aw_cyc++;
            check("aw_addr", bus.axi_aw_addr_o, exp_addr);
            if (k >= aw_dly) aw_done = 1;
         end
         if (bus.axi_w_valid_o) begin
            w_cyc++;
            check("w_strb", bus.axi_w_strb_o, exp_strb);
            check("w_data", bus.axi_w_data_o, exp_data);
            if (k >= w_dly) w_done = 1;
         end
         tick();
      end
      bus.axi_aw_ready_i = 1'b0;
      bus.axi_w_ready_i  = 1'b0;
   endtask

   task automatic read_phase(input int ar_dly, input logic [31:0] exp_addr, output int ar_cyc);
      ar_cyc = 0;
      for (int k = 0; k < 40; k++) begin
         bus.axi_ar_ready_i = (k >= ar_dly);
         if (bus.axi_ar_valid_o) begin
            ar_cyc++;
            if (k == 0) begin
               check("ar_addr", bus.axi_ar_addr_o, exp_addr);
               check("ar_size", bus.axi_ar_size_o, 3'd2);
               check("r_ready_in_read", bus.axi_r_ready_o, 0);
            end
            if (k >= ar_dly) begin
               tick();
               break;
            end
         end
         tick();
      end
      bus.axi_ar_ready_i = 1'b0;
   endtask

   task automatic b_phase(input logic [1:0] resp, output int hs);
      hs = 0;
      bus.axi_b_valid_i = 1'b1;
      bus.axi_b_resp_i  = resp;
      for (int k = 0; k < 20; k++) begin
         if (bus.axi_b_ready_o) begin
            hs++;
            tick();
            break;
         end
         tick();
      end
      bus.axi_b_valid_i = 1'b0;
   endtask

   task automatic r_phase(input logic [63:0] data, input logic [1:0] resp);
      bus.axi_r_valid_i = 1'b1;
      bus.axi_r_data_i  = data;
      bus.axi_r_resp_i  = resp;
      bus.axi_r_last_i  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (bus.axi_r_ready_o) begin
            tick();
            break;
         end
         tick();
      end
      bus.axi_r_valid_i = 1'b0;
   endtask

   // Waits for the OBI response and confirms it is a single-cycle pulse
   task automatic wait_rsp(input int budget, output logic err, output logic [31:0] rdata,
                           output int unsigned rsp_cyc);
      logic got = 1'b0;
      err = 1'b0;
      rdata = '0;
      rsp_cyc = 0;
      for (int k = 0; k < budget; k++) begin
         if (bus.obi_rvalid_o) begin
            got = 1'b1;
            err = bus.obi_err_o;
            rdata = bus.obi_rdata_o;
            rsp_cyc = cyc;
            break;
         end
         tick();
      end
      check("rvalid_seen", got, 1);
      tick();
      check("rvalid_one_cycle", bus.obi_rvalid_o, 0);
   endtask

   initial begin
      int unsigned g, r, e;
      int          awc, wc, arc, hs, extra;
      logic        err;
      logic [31:0] rd;

      bus.obi_req_i = 0; bus.obi_addr_i = 0; bus.obi_we_i = 0; bus.obi_be_i = 0; bus.obi_wdata_i = 0;
      bus.axi_aw_ready_i = 0; bus.axi_w_ready_i = 0; bus.axi_ar_ready_i = 0;
      bus.axi_b_valid_i = 0; bus.axi_b_resp_i = 0;
      bus.axi_r_valid_i = 0; bus.axi_r_data_i = 0; bus.axi_r_resp_i = 0; bus.axi_r_last_i = 0;

      #3;
      check("rst_busy", busy, 0);
      check("rst_b_ready", bus.axi_b_ready_o, 0);
      check("rst_r_ready", bus.axi_r_ready_o, 0);
      check("rst_valids", {bus.axi_aw_valid_o, bus.axi_w_valid_o, bus.axi_ar_valid_o}, 0);
      check("rst_obi_rsp", {bus.obi_rvalid_o, bus.obi_err_o, bus.obi_rdata_o}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("idle_b_ready", bus.axi_b_ready_o, 1);

      // 1: word write to upper lane, zero-wait slave
      issue(32'h1000_0004, 1'b1, 4'hF, 32'hDEAD_BEEF, g);
      check("busy_write", busy, 1);
      check("w_last", bus.axi_w_last_o, 1);
      check("aw_size", bus.axi_aw_size_o, 3'd2);
      write_phase(0, 0, 32'h1000_0004, 8'hF0, 64'hDEAD_BEEF_DEAD_BEEF, awc, wc);
      b_phase(2'b00, hs);
      wait_rsp(20, err, rd, r);
      check("wr_latency", 64'(r - g), 3);
      check("wr_err", err, 0);

      // 2: reads from both lanes
      issue(32'h1000_0004, 1'b0, 4'hF, 32'h0, g);
      read_phase(0, 32'h1000_0004, arc);
      r_phase(64'h1122_3344_5566_7788, 2'b00);
      wait_rsp(20, err, rd, r);
      check("rd_latency", 64'(r - g), 3);
      check("rd_hi_data", rd, 32'h1122_3344);
      check("rd_hi_err", err, 0);
      issue(32'h1000_0000, 1'b0, 4'hF, 32'h0, g);
      read_phase(2, 32'h1000_0000, arc);
      check("ar_held", arc, 3);
      r_phase(64'h1122_3344_5566_7788, 2'b01);
      wait_rsp(20, err, rd, r);
      check("rd_lo_data", rd, 32'h5566_7788);
      check("rd_exokay_err", err, 0);

      // 3: AW ready delayed 4 cycles, W immediate; halfword at unaligned addr
      issue(32'h1000_0006, 1'b1, 4'hC, 32'hA5A5_0000, g);
      write_phase(4, 0, 32'h1000_0006, 8'hC0, 64'hA5A5_0000_A5A5_0000, awc, wc);
      check("aw_valid_cycles", awc, 5);
      check("w_valid_cycles", wc, 1);
      b_phase(2'b00, hs);
      check("b_handshakes", hs, 1);
      wait_rsp(20, err, rd, r);
      check("slow_aw_err", err, 0);
      issue(32'h2000_0000, 1'b1, 4'h3, 32'h0000_1234, g);
      write_phase(0, 2, 32'h2000_0000, 8'h03, 64'h0000_1234_0000_1234, awc, wc);
      check("w_held_cycles", wc, 3);
      b_phase(2'b00, hs);
      wait_rsp(20, err, rd, r);

      // 4: error responses
      issue(32'h1000_0004, 1'b0, 4'hF, 32'h0, g);
      read_phase(0, 32'h1000_0004, arc);
      r_phase(64'hCAFE_F00D_0BAD_F00D, 2'b10);
      wait_rsp(20, err, rd, r);
      check("rd_slverr_err", err, 1);
      check("rd_slverr_data", rd, 32'hCAFE_F00D);
      issue(32'h1000_0000, 1'b1, 4'hF, 32'h1, g);
      write_phase(0, 0, 32'h1000_0000, 8'h0F, 64'h0000_0001_0000_0001, awc, wc);
      b_phase(2'b11, hs);
      wait_rsp(20, err, rd, r);
      check("wr_decerr_err", err, 1);

      // 5: dead slave, watchdog fires, late B absorbed in IDLE
      issue(32'h3000_0000, 1'b1, 4'hF, 32'h5, g);
      write_phase(0, 0, 32'h3000_0000, 8'h0F, 64'h0000_0005_0000_0005, awc, wc);
      e = cyc;
      wait_rsp(40, err, rd, r);
      check("wd_delay", 64'(r - e), 16);
      check("wd_err", err, 1);
      check("wd_rdata", rd, 0);
      check("idle_after_wd", busy, 0);
      b_phase(2'b00, hs);
      check("late_b_accepted", hs, 1);
      extra = 0;
      for (int k = 0; k < 5; k++) begin
         if (bus.obi_rvalid_o) extra++;
         tick();
      end
      check("late_b_no_rsp", extra, 0);

      // 6: asynchronous reset while waiting in RRESP, then a clean read
      issue(32'h1000_0004, 1'b0, 4'hF, 32'h0, g);
      read_phase(0, 32'h1000_0004, arc);
      check("rresp_r_ready", bus.axi_r_ready_o, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_readies", {bus.axi_b_ready_o, bus.axi_r_ready_o}, 0);
      check("arst_valids", {bus.axi_aw_valid_o, bus.axi_w_valid_o, bus.axi_ar_valid_o}, 0);
      check("arst_obi_rsp", {bus.obi_rvalid_o, bus.obi_err_o, bus.obi_rdata_o}, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      issue(32'h1000_0000, 1'b0, 4'hF, 32'h0, g);
      read_phase(0, 32'h1000_0000, arc);
      r_phase(64'h0123_4567_89AB_CDEF, 2'b00);
      wait_rsp(20, err, rd, r);
      check("post_rst_data", rd, 32'h89AB_CDEF);
      check("post_rst_err", err, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
